fifo_pkt_drain: RTL and testbench

Downstream read-side stage for the 16-bit x 32-entry synchronous FIFO. It waits until a full packet's worth of words is buffered, then drains them over the FIFO read interface. The FIFO has a registered dout and one-cycle read latency. Words are presented on a valid/ready stream with last-word framing, and a 2-entry output buffer sustains one word per cycle under backpressure.

---
 rtl/fifo_pkt_drain.sv | 140 ++++++++++++++
 tb/tb_fifo_pkt_drain.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_drain.sv
// Read-side packet drainer for a synchronous FIFO with registered dout.
// Waits for a full packet (or a flush of residual words) and frames it on a valid/ready stream.
module fifo_pkt_drain #(
    parameter int N       = 16,
    parameter int PKT_LEN = 8,
    parameter int CW      = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] fifo_count,
    input  logic          fifo_empty,
    input  logic [N-1:0]  fifo_dout,
    output logic          fifo_r_en,
    output logic          fifo_vld,
    input  logic          flush,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [N-1:0]  m_data,
    output logic          m_last,
    output logic          busy,
    output logic [7:0]    pkt_cnt
);
    typedef enum logic [1:0] {IDLE, STREAM, TAIL} state_t;

    localparam logic [CW-1:0] FULL_LEN = CW'(PKT_LEN);

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_len, w_len_next;
    logic [CW-1:0] r_issued, w_issued_next;
    logic [CW-1:0] r_idx;
    logic          r_inflight;
    logic [1:0]    r_occ;
    logic          r_rd_ptr;
    logic          r_wr_ptr;
    logic [N-1:0]  r_buf_data [2];
    logic          r_buf_last [2];
    logic [7:0]    r_pkt_cnt;

    logic          w_push;
    logic          w_pop;
    logic          w_head_last;
    logic          w_start;
    logic [2:0]    w_committed;

    assign fifo_vld    = 1'b1;
    assign m_valid     = (r_occ != 2'd0);
    assign m_data      = r_buf_data[r_rd_ptr];
    assign w_head_last = r_buf_last[r_rd_ptr];
    assign m_last      = m_valid & w_head_last;
    assign busy        = (r_state != IDLE) | m_valid;
    assign pkt_cnt     = r_pkt_cnt;

    assign w_push = r_inflight;
    assign w_pop  = m_valid & m_ready;
    // Words already owed to the buffer after this cycle's pop; a new read needs a free slot.
    assign w_committed = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_state_next  = r_state;
        w_len_next    = r_len;
        w_issued_next = r_issued;
        w_start       = 1'b0;
        fifo_r_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (fifo_count >= FULL_LEN) begin
                    w_start    = 1'b1;
                    w_len_next = FULL_LEN;
                end else if (flush && (fifo_count != '0)) begin
                    w_start    = 1'b1;
                    w_len_next = fifo_count;
                end
                if (w_start) begin
                    w_state_next  = STREAM;
                    w_issued_next = '0;
                end
            end
            STREAM: begin
                if ((r_issued < r_len) && !fifo_empty && (w_committed < 3'd2)) begin
                    fifo_r_en     = 1'b1;
                    w_issued_next = r_issued + CW'(1);
                    if (w_issued_next == r_len)
                        w_state_next = TAIL;
                end
            end
            TAIL: begin
                if (w_pop && w_head_last)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_idx      <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_pkt_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_len      <= w_len_next;
            r_issued   <= w_issued_next;
            r_inflight <= fifo_r_en;
            if (w_start)
                r_idx <= '0;
            else if (w_push)
                r_idx <= r_idx + CW'(1);
            if (w_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop && w_head_last)
                r_pkt_cnt <= r_pkt_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_last[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_buf_data[r_wr_ptr] <= fifo_dout;
            r_buf_last[r_wr_ptr] <= (r_idx == (r_len - CW'(1)));
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !((r_occ == 2'd2) && w_push && !w_pop));
    a_occ_range: assert property (@(posedge clk) disable iff (rst) r_occ != 2'd3);

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Bench for fifo_pkt_drain: behavioural 32-entry FIFO in front, scoreboard on the output stream.
module tb_fifo_pkt_drain;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  fifo_count;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_r_en;
    logic        fifo_vld;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic [7:0]  pkt_cnt;

    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] fmem [32];
    logic [4:0]  fhead;
    logic [4:0]  ftail;

    typedef struct packed {
        logic        l;
        logic [15:0] d;
    } exp_t;
    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int rd_total  = 0;
    int pop_total = 0;
    int val_total = 0;

    always #5 clk = ~clk;

    fifo_pkt_drain #(.N(16), .PKT_LEN(8), .CW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_r_en  (fifo_r_en),
        .fifo_vld   (fifo_vld),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .pkt_cnt    (pkt_cnt)
    );

    // FIFO model: registered dout, one-cycle read latency, shares rst
    assign fifo_empty = (fifo_count == 6'd0);
    always @(posedge clk) begin
        if (rst) begin
            fhead      <= 5'd0;
            ftail      <= 5'd0;
            fifo_count <= 6'd0;
            fifo_dout  <= 16'd0;
        end else begin
            if (wr_en) begin
                fmem[ftail] <= wr_data;
                ftail       <= ftail + 5'd1;
            end
            if (fifo_r_en) begin
                fifo_dout <= fmem[fhead];
                fhead     <= fhead + 5'd1;
            end
            fifo_count <= fifo_count + 6'(wr_en) - 6'(fifo_r_en);
        end
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic push_exp(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.d = base + 16'(i);
            e.l = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic write_words(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 16'(i);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        chk(done, name, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // Monitor: one line per accepted word, scoreboard compare, stall and credit checks
    initial begin
        bit          prev_stall = 1'b0;
        logic [15:0] prev_data  = 16'd0;
        logic        prev_last  = 1'b0;
        int          rd_since   = 0;
        int          pop_since  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                rd_since   = 0;
                pop_since  = 0;
            end else begin
                if (prev_stall)
                    chk(m_valid && m_data == prev_data && m_last == prev_last, "stall_hold",
                        {15'd0, m_last, m_data}, {15'd0, prev_last, prev_data});
                if (!m_valid)
                    chk(m_last == 1'b0, "last_without_valid", 32'(m_last), 32'd0);
                chk(rd_since - pop_since <= 2, "outstanding_le_2", 32'(rd_since - pop_since), 32'd2);
                if (m_valid && m_ready) begin
                    chk(exp_q.size() > 0, "word_expected", 32'(m_data), 32'd0);
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        $display("word data=0x%04h last=%0d exp=0x%04h/%0d", m_data, m_last, e.d, e.l);
                        chk(m_data == e.d && m_last == e.l, "word",
                            {15'd0, m_last, m_data}, {15'd0, e.l, e.d});
                    end
                    pop_total++;
                    pop_since++;
                end
                if (fifo_r_en) begin
                    rd_total++;
                    rd_since++;
                end
                if (m_valid) val_total++;
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    initial begin
        int first_ren, first_val, ren_cnt, ren_run, ren_max, pop_run, pop_max;
        int rd_snap, val_snap, pop_snap;
        bit hit;

        rst = 1'b1; wr_en = 1'b0; wr_data = 16'd0; flush = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(m_valid == 1'b0,  "rst_m_valid",   32'(m_valid),   32'd0);
        chk(m_data == 16'd0,  "rst_m_data",    32'(m_data),    32'd0);
        chk(m_last == 1'b0,   "rst_m_last",    32'(m_last),    32'd0);
        chk(busy == 1'b0,     "rst_busy",      32'(busy),      32'd0);
        chk(pkt_cnt == 8'd0,  "rst_pkt_cnt",   32'(pkt_cnt),   32'd0);
        chk(fifo_r_en == 1'b0, "rst_fifo_r_en", 32'(fifo_r_en), 32'd0);
        chk(fifo_vld == 1'b1, "rst_fifo_vld",  32'(fifo_vld),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: single 8-word packet at full rate
        push_exp(16'h0001, 8);
        write_words(16'h0001, 8);
        first_ren = -1; first_val = -1; ren_cnt = 0; ren_run = 0; ren_max = 0; pop_run = 0; pop_max = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (fifo_r_en) begin
                ren_cnt++; ren_run++;
                if (first_ren < 0) first_ren = c;
                if (ren_run > ren_max) ren_max = ren_run;
            end else ren_run = 0;
            if (m_valid && first_val < 0) first_val = c;
            if (m_valid && m_ready) begin
                pop_run++;
                if (pop_run > pop_max) pop_max = pop_run;
            end else pop_run = 0;
            if (exp_q.size() == 0 && !busy && first_val >= 0) break;
        end
        chk(ren_cnt == 8, "t1_read_count", 32'(ren_cnt), 32'd8);
        chk(ren_max == 8, "t1_read_consecutive", 32'(ren_max), 32'd8);
        chk(first_val - first_ren == 2, "t1_first_valid_latency", 32'(first_val - first_ren), 32'd2);
        chk(pop_max == 8, "t1_pop_consecutive", 32'(pop_max), 32'd8);
        chk(exp_q.size() == 0, "t1_drained", 32'(exp_q.size()), 32'd0);
        chk(busy == 1'b0, "t1_busy", 32'(busy), 32'd0);
        chk(pkt_cnt == 8'd1, "t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        @(posedge clk); #1;

        // 2: preload with stalled sink, then m_ready pattern 1,0,0
        m_ready = 1'b0;
        push_exp(16'h0101, 8);
        write_words(16'h0101, 8);
        repeat (6) begin @(posedge clk); #1; end
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            m_ready = (i % 3 == 0);
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) hit = 1'b1;
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        chk(hit, "t2_drained", 32'(exp_q.size()), 32'd0);
        chk(pkt_cnt == 8'd2, "t2_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // 3: short packet via flush
        push_exp(16'h00A0, 3);
        write_words(16'h00A0, 3);
        @(posedge clk); #1;
        pulse_flush();
        wait_drain("t3_drain", 100);
        chk(pkt_cnt == 8'd3, "t3_pkt_cnt", 32'(pkt_cnt), 32'd3);

        // 4: flush with empty FIFO is ignored
        rd_snap = rd_total; val_snap = val_total;
        pulse_flush();
        repeat (10) begin @(posedge clk); #1; end
        chk(rd_total == rd_snap, "t4_no_read", 32'(rd_total - rd_snap), 32'd0);
        chk(val_total == val_snap, "t4_no_valid", 32'(val_total - val_snap), 32'd0);
        chk(pkt_cnt == 8'd3, "t4_pkt_cnt", 32'(pkt_cnt), 32'd3);
        chk(busy == 1'b0, "t4_busy", 32'(busy), 32'd0);

        // 5: 20 words -> two back-to-back packets, 4 left behind
        push_exp(16'h0201, 8);
        push_exp(16'h0209, 8);
        write_words(16'h0201, 20);
        wait_drain("t5_drain", 200);
        chk(pkt_cnt == 8'd5, "t5_pkt_cnt", 32'(pkt_cnt), 32'd5);
        rd_snap = rd_total;
        repeat (20) begin @(posedge clk); #1; end
        chk(fifo_count == 6'd4, "t5_residual", 32'(fifo_count), 32'd4);
        chk(rd_total == rd_snap, "t5_no_third", 32'(rd_total - rd_snap), 32'd0);
        chk(busy == 1'b0, "t5_busy", 32'(busy), 32'd0);

        // residual 4 words out as a short packet
        push_exp(16'h0211, 4);
        pulse_flush();
        wait_drain("t5_flush_drain", 100);
        chk(pkt_cnt == 8'd6, "t5_flush_pkt_cnt", 32'(pkt_cnt), 32'd6);

        // 6: reset after the 4th word of a packet is popped
        push_exp(16'h0301, 8);
        pop_snap = pop_total;
        write_words(16'h0301, 8);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            if (pop_total - pop_snap >= 4) hit = 1'b1;
        end
        chk(hit, "t6_reach_4th_pop", 32'(pop_total - pop_snap), 32'd4);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(m_valid == 1'b0,   "t6_m_valid",   32'(m_valid),   32'd0);
        chk(fifo_r_en == 1'b0, "t6_fifo_r_en", 32'(fifo_r_en), 32'd0);
        chk(pkt_cnt == 8'd0,   "t6_pkt_cnt",   32'(pkt_cnt),   32'd0);
        chk(busy == 1'b0,      "t6_busy",      32'(busy),      32'd0);
        chk(m_last == 1'b0,    "t6_m_last",    32'(m_last),    32'd0);
        @(posedge clk); #1;
        push_exp(16'h0401, 8);
        write_words(16'h0401, 8);
        wait_drain("t6_refill_drain", 100);
        chk(pkt_cnt == 8'd1, "t6_refill_pkt_cnt", 32'(pkt_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
